led_frame_sequencer: RTL and testbench

- Frame scheduler between the keyboard RGB/animation controller and the shared WS2812 pixel serializer.
- Each frame tick it snapshots the base colour and animation select, then streams NUM_PIXELS colour words to the serializer over a valid/ready handshake.
- After the last pixel it holds the strip latch gap, then signals frame completion.
- Sole master of the serializer input; owns all animation timing (chase phase, blink, fade ramp).

---
 rtl/led_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// Frame scheduler: on each frame tick, snapshots colour/animation and streams NUM_PIXELS words to the
// WS2812 serializer, then holds the latch gap. Define GAMMA_CORRECT_EN to square each channel ((c*c)>>8).
module led_frame_sequencer #(
  parameter int NUM_PIXELS   = 16,
  parameter int TICK_DIV     = 833333,
  parameter int LATCH_CYCLES = 2600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic [3:0]  anim_sel,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        pix_last,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        overrun
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (NUM_PIXELS > 2) ? $clog2(NUM_PIXELS) : 1;
  localparam int GW = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
  logic [3:0]      sh_sel_q, sh_sel_d;

  logic            tick, go_load, gap_end, last_idx;
  logic [7:0]      lvl, anim_r, anim_g, anim_b;

  // Upper byte of an 8x8 product; shared by fade scaling and gamma squaring.
  function automatic logic [7:0] mul_hi(input logic [7:0] a, input logic [7:0] c);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, c};
    return p[15:8];
  endfunction

  function automatic logic [7:0] gamma(input logic [7:0] c);
`ifdef GAMMA_CORRECT_EN
    return mul_hi(c, c);
`else
    return c;
`endif
  endfunction

  assign tick     = enable && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign go_load  = (state_q == IDLE) && enable && (pending_q || tick);
  assign gap_end  = (state_q == GAP) && (gap_cnt_q == GW'(LATCH_CYCLES - 1));
  assign last_idx = (idx_q == PW'(NUM_PIXELS - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    sh_r_d        = sh_r_q;
    sh_g_d        = sh_g_q;
    sh_b_d        = sh_b_q;
    sh_sel_d      = sh_sel_q;
    tick_cnt_d    = (!enable || tick) ? '0 : tick_cnt_q + TW'(1);
    // A tick that finds a frame already queued is dropped and flagged.
    overrun_d     = overrun_q | (tick & pending_q);
    pending_d     = go_load ? 1'b0 : (tick ? 1'b1 : pending_q);
    case (state_q)
      IDLE: if (go_load) state_d = LOAD;
      LOAD: begin
        sh_r_d   = r;
        sh_g_d   = g;
        sh_b_d   = b;
        sh_sel_d = anim_sel;
        idx_d    = '0;
        state_d  = SEND;
      end
      SEND: if (pix_ready) begin
        if (last_idx) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          idx_d = idx_q + PW'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          state_d       = IDLE;
          frame_count_d = frame_count_q + 8'd1;
          phase_d       = (phase_q == PW'(NUM_PIXELS - 1)) ? '0 : phase_q + PW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      idx_q         <= '0;
      phase_q       <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
    end
  end

  // Shadow colour/animation carry data only; the SEND gate keeps them invisible until loaded.
  always_ff @(posedge clk) begin
    sh_r_q   <= sh_r_d;
    sh_g_q   <= sh_g_d;
    sh_b_q   <= sh_b_d;
    sh_sel_q <= sh_sel_d;
  end

  assign lvl = frame_count_q[7] ? {~frame_count_q[6:0], 1'b0} : {frame_count_q[6:0], 1'b0};

  always_comb begin
    anim_r = sh_r_q;
    anim_g = sh_g_q;
    anim_b = sh_b_q;
    case (sh_sel_q)
      4'd0: begin
        anim_r = '0;
        anim_g = '0;
        anim_b = '0;
      end
      4'd2: if (idx_q != phase_q) begin
        anim_r = '0;
        anim_g = '0;
        anim_b = '0;
      end
      4'd3: if (!frame_count_q[4]) begin
        anim_r = '0;
        anim_g = '0;
        anim_b = '0;
      end
      4'd4: begin
        anim_r = mul_hi(sh_r_q, lvl);
        anim_g = mul_hi(sh_g_q, lvl);
        anim_b = mul_hi(sh_b_q, lvl);
      end
      4'd5: if (idx_q[0]) begin
        anim_r = ~sh_r_q;
        anim_g = ~sh_g_q;
        anim_b = ~sh_b_q;
      end
      default: ;
    endcase
  end

  assign pix_valid   = (state_q == SEND);
  assign pix_last    = pix_valid && last_idx;
  assign pix_data    = pix_valid ? {gamma(anim_g), gamma(anim_r), gamma(anim_b)} : 24'd0;
  assign frame_done  = gap_end;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: directed scenarios plus randomized traffic checked every cycle
// against a frame-level behavioural model. Honours GAMMA_CORRECT_EN when defined.
`timescale 1ns/1ps
module tb_led_frame_sequencer;
  localparam int NP = 4;
  localparam int TD = 20;
  localparam int LC = 5;
`ifdef GAMMA_CORRECT_EN
  localparam logic [23:0] W1  = 24'h0A011C;
  localparam logic [7:0]  R12 = 8'h01;
  localparam logic [7:0]  RFF = 8'hFE;
  localparam logic [7:0]  R80 = 8'h40;
`else
  localparam logic [23:0] W1  = 24'h341256;
  localparam logic [7:0]  R12 = 8'h12;
  localparam logic [7:0]  RFF = 8'hFF;
  localparam logic [7:0]  R80 = 8'h80;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, pix_ready = 1'b0;
  logic [7:0] r = 8'h00, g = 8'h00, b = 8'h00;
  logic [3:0] anim_sel = 4'd0;
  logic pix_valid, pix_last, frame_done, overrun;
  logic [23:0] pix_data;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  led_frame_sequencer #(.NUM_PIXELS(NP), .TICK_DIV(TD), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .r(r), .g(g), .b(b), .anim_sel(anim_sel),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int gam(input int c);
`ifdef GAMMA_CORRECT_EN
    return (c * c) / 256;
`else
    return c;
`endif
  endfunction

  function automatic int anim_ch(input int mode, input int c, input int i, input int fc, input int ph);
    case (mode)
      0: return 0;
      2: return (i == ph) ? c : 0;
      3: return ((fc / 16) % 2 == 1) ? c : 0;
      4: return (c * ((fc < 128) ? 2 * fc : 2 * (255 - fc))) / 256;
      5: return (i % 2 == 0) ? c : 255 - c;
      default: return c;
    endcase
  endfunction

  function automatic logic [23:0] exp_word(input int mode, input int rr, input int gg, input int bb,
                                           input int i, input int fc, input int ph);
    return {8'(gam(anim_ch(mode, gg, i, fc, ph))), 8'(gam(anim_ch(mode, rr, i, fc, ph))),
            8'(gam(anim_ch(mode, bb, i, fc, ph)))};
  endfunction

  int m_tick, m_fc, m_ph, m_sent, m_gap, s_r, s_g, s_b, s_m;
  bit m_pend, m_over, m_load, m_send, m_ok, m_tk, m_start;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_tick = 0; m_fc = 0; m_ph = 0; m_sent = 0; m_gap = 0;
      m_pend = 0; m_over = 0; m_load = 0; m_send = 0; m_ok = 1;
    end else begin
      m_tk = enable && (m_tick == TD - 1);
      m_start = 0;
      if (m_load) begin
        s_r = int'(r); s_g = int'(g); s_b = int'(b); s_m = int'(anim_sel);
        m_load = 0; m_send = 1; m_sent = 0;
      end else if (m_send) begin
        if (pix_ready) begin
          m_sent++;
          if (m_sent == NP) begin m_send = 0; m_gap = LC; end
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin m_fc = (m_fc + 1) % 256; m_ph = (m_ph + 1) % NP; end
      end else if (enable && (m_pend || m_tk)) begin
        m_load = 1; m_start = 1;
      end
      if (m_tk && m_pend) m_over = 1;
      if (m_start) m_pend = 0;
      else if (m_tk) m_pend = 1;
      m_tick = (enable && !m_tk) ? m_tick + 1 : 0;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("valid", 32'(pix_valid), 32'(m_send));
      chk("last", 32'(pix_last), 32'(m_send && m_sent == NP - 1));
      chk("frame_done", 32'(frame_done), 32'(m_gap == 1));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      chk("overrun", 32'(overrun), 32'(m_over));
      if (m_send) chk("data", 32'(pix_data), 32'(exp_word(s_m, s_r, s_g, s_b, m_sent, m_fc, m_ph)));
    end
  end

  // Handshakes per frame and stall stability, independent of the model.
  int hs = 0;
  bit p_v = 0, p_r = 0, p_l = 0;
  logic [23:0] p_d = '0;
  initial forever begin
    @(negedge clk);
    if (p_v && !p_r && pix_valid) begin
      chk("stall_data", 32'(pix_data), 32'(p_d));
      chk("stall_last", 32'(pix_last), 32'(p_l));
    end
    p_v = pix_valid; p_r = pix_ready; p_d = pix_data; p_l = pix_last;
    if (pix_valid && pix_ready) hs++;
    if (frame_done) begin
      chk("hs_per_frame", 32'(hs), 32'(NP));
      hs = 0;
    end
    if (reset) hs = 0;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!pix_valid && k < 200) begin cyc(); k++; end
    chk({name, "_valid"}, 32'(pix_valid), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!frame_done && k < 300) begin cyc(); k++; end
    chk({name, "_done"}, 32'(frame_done), 32'd1);
  endtask

  int n;
  int lit_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    cyc(3);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);

    // Mode 1, no backpressure
    r = 8'h12; g = 8'h34; b = 8'h56; anim_sel = 4'd1; pix_ready = 1; enable = 1; reset = 0;
    wait_valid("m1");
    for (int w = 0; w < NP; w++) begin
      chk("m1_word", 32'(pix_data), 32'(W1));
      chk("m1_last", 32'(pix_last), 32'(w == NP - 1));
      cyc();
    end
    n = 1;
    while (!frame_done && n < 50) begin cyc(); n++; end
    chk("m1_gap_len", 32'(n), 32'd5);
    chk("m1_fc_before", 32'(frame_count), 32'd0);
    cyc();
    chk("m1_fc_after", 32'(frame_count), 32'd1);

    // Backpressure: 1 cycle ready, 2 stalled
    for (int k = 0; k < 80; k++) begin
      pix_ready = (k % 3 == 0);
      cyc();
    end
    pix_ready = 1;

    // Chase over 5 frames from a fresh reset
    reset = 1; anim_sel = 4'd2;
    cyc(2);
    reset = 0;
    for (int f = 0; f < 5; f++) begin
      wait_valid("m2");
      for (int w = 0; w < NP; w++) begin
        if (w == lit_exp[f]) chk("m2_lit", 32'(pix_data), 32'(W1));
        else chk("m2_dark", 32'(pix_data), 32'd0);
        cyc();
      end
      wait_done("m2");
      cyc();
    end

    // Snapshot: r changes mid-frame
    anim_sel = 4'd1;
    wait_valid("snap");
    chk("snap_w0_r", 32'(pix_data[15:8]), 32'(R12));
    cyc();
    r = 8'hFF;
    for (int w = 1; w < NP; w++) begin
      chk("snap_old_r", 32'(pix_data[15:8]), 32'(R12));
      cyc();
    end
    wait_done("snap");
    cyc();
    wait_valid("snap2");
    chk("snap_new_r", 32'(pix_data[15:8]), 32'(RFF));
    wait_done("snap2");
    cyc();

    // Overrun: long stall
    pix_ready = 0;
    wait_valid("ovr");
    cyc(45);
    chk("ovr_set", 32'(overrun), 32'd1);
    pix_ready = 1;
    wait_done("ovr");
    chk("ovr_sticky", 32'(overrun), 32'd1);
    cyc();

    // Reset mid-SEND, then mode 1 with r=0x80
    pix_ready = 0;
    wait_valid("rst");
    cyc(2);
    reset = 1;
    cyc();
    chk("rst_mid_valid", 32'(pix_valid), 32'd0);
    chk("rst_mid_fc", 32'(frame_count), 32'd0);
    chk("rst_mid_ovr", 32'(overrun), 32'd0);
    reset = 0; r = 8'h80; pix_ready = 1;
    wait_valid("gam");
    chk("gam_r80", 32'(pix_data[15:8]), 32'(R80));
    wait_done("gam");
    cyc();

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) anim_sel = 4'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 299) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      reset = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    reset = 0; pix_ready = 1;
    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
